ir_nec_tx: RTL and testbench

Complete NEC infrared frame transmitter. It generates a parametrised carrier with a drift-free fractional accumulator and gates that carrier with an NEC mark/space sequencer. The block accepts an address/command pair over a ready/start handshake and emits a full modulated frame on ir_out. It sits between the game controller logic and the IR LED driver pin.

---
 rtl/ir_nec_tx.sv | 177 +++++++++++++++++
 tb/tb_ir_nec_tx.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/ir_nec_tx.sv
// NEC infrared frame transmitter: fractional-accumulator carrier gated by an NEC mark/space sequencer.
// Optional repeat-code support is enabled with the IR_REPEAT_EN macro.
module ir_nec_tx #(
    parameter int FCLK       = 50_000_000,
    parameter int CARRIER_HZ = 38_000,
    parameter int UNIT_HZ    = 1_778
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic [7:0] addr,
    input  logic [7:0] cmd,
    input  logic       rpt,
    output logic       ready,
    output logic       busy,
    output logic       done,
    output logic       ir_out
);

    localparam int UNIT_CYC = FCLK / UNIT_HZ;
    localparam int ACC_W    = $clog2(FCLK) + 1;
    localparam int UNIT_W   = $clog2(UNIT_CYC);

    localparam logic [ACC_W-1:0]  STEP      = ACC_W'(2 * CARRIER_HZ);
    localparam logic [ACC_W-1:0]  WRAP      = ACC_W'(FCLK);
    localparam logic [UNIT_W-1:0] UNIT_LAST = UNIT_W'(UNIT_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEAD_MARK,
        S_LEAD_SPACE,
        S_BIT_MARK,
        S_BIT_SPACE,
`ifdef IR_REPEAT_EN
        S_RPT_SPACE,
`endif
        S_STOP_MARK
    } state_t;

    state_t            state_q, state_d;
    logic [ACC_W-1:0]  acc_q, acc_d, acc_sum;
    logic              carrier_q, carrier_d;
    logic [UNIT_W-1:0] unit_q, unit_d;
    logic [4:0]        dur_q, dur_d, dur_last;
    logic [31:0]       shreg_q, shreg_d;
    logic [5:0]        bit_q, bit_d;
    logic              rpt_q, rpt_d;
    logic              done_d, ir_d, mark_d;
    logic              unit_end, state_end, accept;

    assign acc_sum   = acc_q + STEP;
    assign unit_end  = (unit_q == UNIT_LAST);
    assign state_end = unit_end && (dur_q == dur_last);
    assign accept    = start && (state_q == S_IDLE);
    assign ready     = (state_q == S_IDLE);
    assign busy      = ~ready;

`ifndef IR_REPEAT_EN
    logic unused_rpt;
    assign unused_rpt = rpt_q;
`endif

    // Last unit index (duration - 1) of the current state.
    always_comb begin
        dur_last = 5'd0;
        case (state_q)
            S_LEAD_MARK:  dur_last = 5'd15;
            S_LEAD_SPACE: dur_last = 5'd7;
            S_BIT_SPACE:  dur_last = shreg_q[0] ? 5'd2 : 5'd0;
`ifdef IR_REPEAT_EN
            S_RPT_SPACE:  dur_last = 5'd3;
`endif
            default:      dur_last = 5'd0;
        endcase
    end

    // NOTE: every output of this block gets a default first, so no path can leave one unassigned and infer a latch.
    always_comb begin
        state_d   = state_q;
        unit_d    = '0;
        dur_d     = dur_q;
        shreg_d   = shreg_q;
        bit_d     = bit_q;
        rpt_d     = rpt_q;
        done_d    = 1'b0;

        // The remainder is carried over, so the long-term carrier rate is exact.
        if (acc_sum >= WRAP) begin
            acc_d     = acc_sum - WRAP;
            carrier_d = ~carrier_q;
        end else begin
            acc_d     = acc_sum;
            carrier_d = carrier_q;
        end

        if (state_q != S_IDLE) begin
            unit_d = unit_end ? '0 : unit_q + 1'b1;
            if (unit_end) begin
                dur_d = state_end ? 5'd0 : dur_q + 5'd1;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d   = S_LEAD_MARK;
                    acc_d     = '0;
                    carrier_d = 1'b0;
                    dur_d     = 5'd0;
                    shreg_d   = {~cmd, cmd, ~addr, addr};
                    bit_d     = 6'd0;
                    rpt_d     = rpt;
                end
            end
            S_LEAD_MARK: begin
                if (state_end) begin
`ifdef IR_REPEAT_EN
                    state_d = rpt_q ? S_RPT_SPACE : S_LEAD_SPACE;
`else
                    state_d = S_LEAD_SPACE;
`endif
                end
            end
            S_LEAD_SPACE: if (state_end) state_d = S_BIT_MARK;
            S_BIT_MARK:   if (state_end) state_d = S_BIT_SPACE;
            S_BIT_SPACE: begin
                if (state_end) begin
                    shreg_d = {1'b0, shreg_q[31:1]};
                    bit_d   = bit_q + 6'd1;
                    state_d = (bit_q == 6'd31) ? S_STOP_MARK : S_BIT_MARK;
                end
            end
`ifdef IR_REPEAT_EN
            S_RPT_SPACE:  if (state_end) state_d = S_STOP_MARK;
`endif
            S_STOP_MARK: begin
                if (state_end) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        mark_d = (state_d == S_LEAD_MARK) || (state_d == S_BIT_MARK) ||
                 (state_d == S_STOP_MARK);
        ir_d   = carrier_d & mark_d;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            acc_q     <= '0;
            carrier_q <= 1'b0;
            unit_q    <= '0;
            done      <= 1'b0;
            ir_out    <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            carrier_q <= carrier_d;
            unit_q    <= unit_d;
            done      <= done_d;
            ir_out    <= ir_d;
        end
    end

    // NOTE: payload and counters are reloaded on every acceptance, so they carry no reset.
    always_ff @(posedge clk) begin
        dur_q   <= dur_d;
        shreg_q <= shreg_d;
        bit_q   <= bit_d;
        rpt_q   <= rpt_d;
    end

endmodule

// File: tb/tb_ir_nec_tx.sv
// Randomized self-checking bench for ir_nec_tx: every cycle of each frame is compared against
// a unit-level NEC waveform model; honours IR_REPEAT_EN for the repeat-code expectation.
module tb_ir_nec_tx;

    localparam int FCLK       = 76_000;
    localparam int CARRIER_HZ = 3_800;
    localparam int UNIT_HZ    = 1_000;
    localparam int UC         = FCLK / UNIT_HZ;
`ifdef IR_REPEAT_EN
    localparam bit REPEAT_EN = 1'b1;
`else
    localparam bit REPEAT_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] addr = 8'h00;
    logic [7:0] cmd = 8'h00;
    logic       rpt = 1'b0;
    logic       ready, busy, done, ir_out;

    int total = 0;
    int bad = 0;
    bit exp_units[$];

    always #5 clk = ~clk;

    ir_nec_tx #(
        .FCLK      (FCLK),
        .CARRIER_HZ(CARRIER_HZ),
        .UNIT_HZ   (UNIT_HZ)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .start  (start),
        .addr   (addr),
        .cmd    (cmd),
        .rpt    (rpt),
        .ready  (ready),
        .busy   (busy),
        .done   (done),
        .ir_out (ir_out)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Mark/space pattern of a whole transmission, one entry per NEC unit.
    task automatic fill_units(input logic [7:0] a, input logic [7:0] c, input bit r);
        logic [7:0] bytes [4];
        exp_units.delete();
        repeat (16) exp_units.push_back(1'b1);
        if (r && REPEAT_EN) begin
            repeat (4) exp_units.push_back(1'b0);
            exp_units.push_back(1'b1);
            return;
        end
        repeat (8) exp_units.push_back(1'b0);
        bytes[0] = a;
        bytes[1] = ~a;
        bytes[2] = c;
        bytes[3] = ~c;
        for (int b = 0; b < 4; b++) begin
            for (int i = 0; i < 8; i++) begin
                exp_units.push_back(1'b1);
                repeat (bytes[b][i] ? 3 : 1) exp_units.push_back(1'b0);
            end
        end
        exp_units.push_back(1'b1);
    endtask

    // Carrier level k cycles after acceptance: half-periods elapsed since the phase reset.
    function automatic bit carrier_at(input int k);
        longint half_periods;
        half_periods = (longint'(k - 1) * 2 * CARRIER_HZ) / FCLK;
        return (half_periods % 2) == 1;
    endfunction

    // Entered at a falling edge with the transmitter idle; returns at the falling edge of the
    // done cycle (start still high when hold=1), or after an abort sequence.
    task automatic run_frame(input logic [7:0] a, input logic [7:0] c, input bit r,
                             input bit hold, input int poke_at, input int abort_at,
                             input string tag);
        int         len;
        bit         failed;
        logic [3:0] want, got;
        int         n_done;
        failed = 1'b0;
        fill_units(a, c, r);
        len = exp_units.size() * UC;
        check({tag, "_ready_at_start"}, {31'd0, ready}, 32'd1);
        start = 1'b1;
        addr  = a;
        cmd   = c;
        rpt   = r;
        for (int k = 1; k <= len + 1; k++) begin
            @(negedge clk);
            if (!hold && k == 1) start = 1'b0;
            got  = {ready, busy, done, ir_out};
            want = (k <= len) ? {3'b010, exp_units[(k - 1) / UC] & carrier_at(k)} : 4'b1010;
            if (!failed) begin
                check({tag, "_wave"}, {28'd0, got}, {28'd0, want});
                failed = (got !== want);
            end
            if (k == poke_at) begin
                start = 1'b1;
                addr  = 8'($urandom);
                cmd   = 8'($urandom);
            end
            if (k == poke_at + 1) start = 1'b0;
            if (k == abort_at) begin
                reset_n = 1'b0;
                @(negedge clk);
                reset_n = 1'b1;
                check({tag, "_after_reset"}, {28'd0, ready, busy, done, ir_out}, 32'b1000);
                n_done = 0;
                repeat (300) begin
                    @(negedge clk);
                    if (done) n_done++;
                end
                check({tag, "_no_done"}, n_done, 0);
                return;
            end
        end
    endtask

    initial begin
        bit idle_failed;
        logic [3:0] idle_got;
        idle_failed = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            idle_got = {ready, busy, done, ir_out};
            if (!idle_failed) begin
                check("idle", {28'd0, idle_got}, 32'b1000);
                idle_failed = (idle_got !== 4'b1000);
            end
        end

        run_frame(8'h00, 8'h00, 1'b0, 1'b0, 0, 0, "zero");
        repeat (2) @(negedge clk);

        // Held start: second frame must be accepted in the done cycle.
        run_frame(8'hA5, 8'h3C, 1'b0, 1'b1, 0, 0, "a5_3c");
        run_frame(8'($urandom), 8'($urandom), 1'($urandom), 1'b0, 0, 0, "back2back");
        repeat (3) @(negedge clk);

        run_frame(8'($urandom), 8'($urandom), 1'b0, 1'b0, 5000, 0, "busy_poke");
        repeat (2) @(negedge clk);

        run_frame(8'($urandom), 8'($urandom), 1'b0, 1'b0, 0, 3000, "abort");
        run_frame(8'($urandom), 8'($urandom), 1'b0, 1'b0, 0, 0, "post_abort");
        repeat (2) @(negedge clk);

        run_frame(8'($urandom), 8'($urandom), 1'b1, 1'b0, 0, 0, "rpt_req");
        repeat (5) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
